// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : connect4_pkg
// Purpose  : Shared constants and types for the Connect-4 datapath. Holds the
//            SPI move-frame layout used by spi_move_receiver and the highest
//            legal column index shared with the loader/victory logic.
// Revision : 1.0 - initial release
// ============================================================================
package connect4_pkg;

   // Move frame, MSB first: [7:4] header, [3] even parity, [2:0] column
   localparam int         c_frame_width  = 8;
   localparam logic [3:0] c_frame_header = 4'b1010;
   localparam int         c_max_col      = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RX    = 2'd1,
      CHECK = 2'd2,
      DRAIN = 2'd3
   } spi_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Multi-stage synchronizer for one asynchronous pin, followed by a
//            history register so that single-cycle rise/fall strobes can be
//            derived from the synchronized level.
// Ports    : clk, rst (async, active high)
//            din   - raw asynchronous input
//            level - synchronized level
//            rise  - one-cycle strobe, synchronized 0->1
//            fall  - one-cycle strobe, synchronized 1->0
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   // Fewer than two stages is not a metastability-safe synchronizer
   localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

   logic [DEPTH-1:0] sync_q, sync_d;
   logic             prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[DEPTH-2:0], din};
      prev_d = sync_q[DEPTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {DEPTH{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[DEPTH-1];
   assign rise  =  sync_q[DEPTH-1] & ~prev_q;
   assign fall  = ~sync_q[DEPTH-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_move_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_move_receiver
// Purpose  : SPI mode-0 slave receiving player-2 moves. Assembles one 8-bit
//            frame per ss-low window, validates header/parity/column and
//            hands a valid column to the game controller.
// Ports    : clk, rst (async, active high)
//            sck, ss, mosi - raw SPI pins, asynchronous to clk
//            jugada        - last valid column, held until next valid frame
//            dato_listo    - one-cycle strobe, new valid jugada
//            recibido      - ack level, valid frame until next ss fall
//            frame_error   - one-cycle strobe, frame rejected
// Revision : 1.0 - initial release
// ============================================================================
module spi_move_receiver
   import connect4_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int MAX_COL        = c_max_col
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ss,
   input  logic       mosi,
   output logic [2:0] jugada,
   output logic       dato_listo,
   output logic       recibido,
   output logic       frame_error
);

   localparam int               TO_W          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]  c_timeout_max = TO_W'(TIMEOUT_CYCLES);
   localparam logic [2:0]       c_max_col_w   = 3'(MAX_COL);

   // ---------------------------------------------------------------- sync
   logic w_sck_lvl, w_sck_rise, w_sck_fall;
   logic w_ss_lvl,  w_ss_rise,  w_ss_fall;
   logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .din(sck),
      .level(w_sck_lvl), .rise(w_sck_rise), .fall(w_sck_fall)
   );

   // ss idles high so a reset never fabricates a falling edge by itself
   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk(clk), .rst(rst), .din(ss),
      .level(w_ss_lvl), .rise(w_ss_rise), .fall(w_ss_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(mosi),
      .level(w_mosi_lvl), .rise(w_mosi_rise), .fall(w_mosi_fall)
   );

   logic w_unused_edges;
   assign w_unused_edges = ^{w_sck_lvl, w_sck_fall, w_mosi_rise, w_mosi_fall};

   // --------------------------------------------------------------- state
   spi_rx_state_t            state_q, state_d;
   logic [c_frame_width-1:0] shift_q, shift_d;
   logic [3:0]               bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]          timeout_q, timeout_d;
   logic [2:0]               jugada_q, jugada_d;
   logic                     recibido_q, recibido_d;
   logic                     drain_first_q, drain_first_d;
   logic                     w_frame_ok;

   assign w_frame_ok = (bit_cnt_q == 4'd8)
                    && (shift_q[7:4] == c_frame_header)
                    && !(^shift_q[3:0])
                    && (shift_q[2:0] <= c_max_col_w);

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      timeout_d     = timeout_q;
      jugada_d      = jugada_q;
      recibido_d    = recibido_q;
      drain_first_d = 1'b0;
      dato_listo    = 1'b0;
      frame_error   = 1'b0;

      case (state_q)
         IDLE: begin
            if (w_ss_fall) begin
               shift_d    = '0;
               bit_cnt_d  = '0;
               timeout_d  = '0;
               recibido_d = 1'b0;   // Arduino handshake: slave ready again
               state_d    = RX;
            end
         end

         RX: begin
            if (w_sck_rise) begin
               shift_d   = {shift_q[c_frame_width-2:0], w_mosi_lvl};
               timeout_d = '0;
               if (bit_cnt_q != 4'd9) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (timeout_q != c_timeout_max) begin
               timeout_d = timeout_q + TO_W'(1);
            end

            // ss rise wins: an overlong frame still fails in CHECK
            if (w_ss_rise) begin
               state_d = CHECK;
            end else if ((bit_cnt_d == 4'd9) || (timeout_d == c_timeout_max)) begin
               state_d       = DRAIN;
               drain_first_d = 1'b1;
            end
         end

         CHECK: begin
            if (w_frame_ok) begin
               jugada_d   = shift_q[2:0];
               recibido_d = 1'b1;
               dato_listo = 1'b1;
            end else begin
               frame_error = 1'b1;
            end
            state_d = IDLE;
         end

         DRAIN: begin
            // Error was already reported on entry; leave silently
            frame_error = drain_first_q;
            if (w_ss_lvl) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         timeout_q     <= '0;
         jugada_q      <= 3'd0;
         recibido_q    <= 1'b0;
         drain_first_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         timeout_q     <= timeout_d;
         jugada_q      <= jugada_d;
         recibido_q    <= recibido_d;
         drain_first_q <= drain_first_d;
      end
   end

   assign jugada   = jugada_q;
   assign recibido = recibido_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_move_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_move_receiver
// Purpose  : Self-checking bench for spi_move_receiver: directed frame table,
//            handshake / timeout / mid-frame reset sequences and randomized
//            frames checked against a rule-level frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_move_receiver;

   localparam int TO = 100;
   localparam int SS = 2;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       sck  = 1'b0;
   logic       ss   = 1'b1;
   logic       mosi = 1'b0;
   logic [2:0] jugada;
   logic       dato_listo, recibido, frame_error;

   int n_vec = 0;
   int n_err = 0;
   int dl_cnt = 0, fe_cnt = 0, ov_cnt = 0;
   logic [2:0] model_jug = 3'd0;

   always #5 clk = ~clk;

   spi_move_receiver #(
      .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .MAX_COL(6)
   ) dut (
      .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi),
      .jugada(jugada), .dato_listo(dato_listo), .recibido(recibido),
      .frame_error(frame_error)
   );

   // Strobe counters; tasks take differences of snapshots
   always @(negedge clk) begin
      if (dato_listo)                 dl_cnt++;
      if (frame_error)                fe_cnt++;
      if (dato_listo && frame_error)  ov_cnt++;
   end

   typedef struct {
      logic [7:0] frame;
      int         nbits;
      bit         exp_ok;
      logic [2:0] exp_jug;
      string      name;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Acceptance rule stated directly: exactly 8 bits, header 1010,
   // an even number of ones in the low nibble, column not above 6
   function automatic bit model_ok(input logic [7:0] fr, input int nbits);
      int col;
      col = int'(fr[2:0]);
      return (nbits == 8) && (fr[7:4] == 4'b1010)
          && (($countones(fr[3:0]) % 2) == 0) && (col <= 6);
   endfunction

   task automatic run_frame(input logic [7:0] fr, input int nbits,
                            input bit exp_ok, input logic [2:0] exp_jug,
                            input string name);
      int dl0, fe0, ov0, fe_pre, lat;
      bit seen;
      dl0 = dl_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
      @(negedge clk) ss = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 8) ? fr[7-i] : 1'b0;
         repeat (4) @(negedge clk);
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
      repeat (4) @(negedge clk);
      fe_pre = fe_cnt - fe0;
      ss = 1'b1;
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (!seen && (dato_listo || frame_error)) begin
            seen = 1'b1; lat = k;
         end
      end
      chk({name, " dato_listo_pulses"}, dl_cnt - dl0, exp_ok ? 1 : 0);
      chk({name, " frame_error_pulses"}, fe_cnt - fe0, exp_ok ? 0 : 1);
      chk({name, " error_before_ss_rise"}, fe_pre, (nbits > 8) ? 1 : 0);
      chk({name, " strobe_overlap"}, ov_cnt - ov0, 0);
      chk({name, " jugada"}, int'(jugada), int'(exp_jug));
      chk({name, " recibido"}, int'(recibido), exp_ok ? 1 : 0);
      // Pin changes at negedge; SS sync posedges detect the rise and the
      // next posedge enters CHECK, so the strobe is seen at negedge SS+1
      if (nbits <= 8) chk({name, " strobe_latency"}, lat, SS + 1);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dl0, fe0, k_hit;
      bit found;
      logic [7:0] fr;
      int nb;
      bit ok;

      tbl[0] = '{8'b1010_0_011, 8, 1'b1, 3'd3, "col3_good"};
      tbl[1] = '{8'b1010_1_111, 8, 1'b0, 3'd3, "col7_bad"};
      tbl[2] = '{8'b1010_1_011, 8, 1'b0, 3'd3, "parity_bad"};
      tbl[3] = '{8'b0110_0_011, 8, 1'b0, 3'd3, "header_bad"};
      tbl[4] = '{8'b1010_0_011, 5, 1'b0, 3'd3, "short5"};
      tbl[5] = '{8'b1010_0_011, 9, 1'b0, 3'd3, "long9"};
      tbl[6] = '{8'b1010_0_101, 8, 1'b1, 3'd5, "col5_good"};

      // ------------------------------------------------ reset state
      repeat (3) @(negedge clk);
      chk("reset jugada", int'(jugada), 0);
      chk("reset dato_listo", int'(dato_listo), 0);
      chk("reset recibido", int'(recibido), 0);
      chk("reset frame_error", int'(frame_error), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // ------------------------------------------------ directed table
      for (int v = 0; v < 7; v++) begin
         run_frame(tbl[v].frame, tbl[v].nbits, tbl[v].exp_ok,
                   tbl[v].exp_jug, tbl[v].name);
      end
      model_jug = 3'd5;

      // ------------------------------------------------ ss-fall handshake
      fe0 = fe_cnt; dl0 = dl_cnt;
      @(negedge clk) ss = 1'b0;
      repeat (6) @(negedge clk);
      chk("handshake recibido_drop", int'(recibido), 0);
      ss = 1'b1;
      repeat (10) @(negedge clk);
      chk("handshake empty_frame_error", fe_cnt - fe0, 1);
      chk("handshake no_dato_listo", dl_cnt - dl0, 0);
      chk("handshake jugada_held", int'(jugada), 5);

      // ------------------------------------------------ random frames
      for (int r = 0; r < 24; r++) begin
         case ($urandom_range(0, 3))
            0: fr = 8'($urandom);
            1: begin
               fr[7:4] = 4'b1010;
               fr[2:0] = 3'($urandom_range(0, 7));
               fr[3]   = 1'($urandom);
            end
            default: begin
               fr[7:4] = 4'b1010;
               fr[2:0] = 3'($urandom_range(0, 7));
               fr[3]   = 1'($countones(fr[2:0]) % 2);
            end
         endcase
         case ($urandom_range(0, 9))
            0:       nb = 7;
            1:       nb = 9;
            default: nb = 8;
         endcase
         ok = model_ok(fr, nb);
         if (ok) model_jug = fr[2:0];
         run_frame(fr, nb, ok, model_jug, "random");
      end

      // ------------------------------------------------ timeout
      fe0 = fe_cnt; dl0 = dl_cnt;
      found = 1'b0; k_hit = 0;
      @(negedge clk) ss = 1'b0;
      for (int k = 1; k <= TO + 40; k++) begin
         @(negedge clk);
         if (frame_error && !found) begin
            found = 1'b1; k_hit = k;
         end
      end
      chk("timeout fired", int'(found), 1);
      // SS+1 cycles to enter RX, then TO idle cycles to reach the limit
      chk("timeout cycle", k_hit, TO + SS + 1);
      for (int p = 0; p < 3; p++) begin
         mosi = 1'(p);
         repeat (4) @(negedge clk); sck = 1'b1;
         repeat (4) @(negedge clk); sck = 1'b0;
      end
      ss = 1'b1;
      repeat (10) @(negedge clk);
      chk("timeout single_error", fe_cnt - fe0, 1);
      chk("timeout no_dato_listo", dl_cnt - dl0, 0);
      chk("timeout jugada_held", int'(jugada), int'(model_jug));

      // ------------------------------------------------ mid-frame reset
      model_jug = 3'd3;
      run_frame(8'b1010_0_011, 8, 1'b1, 3'd3, "pre_reset");
      @(negedge clk) ss = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         mosi = 1'b1;
         repeat (4) @(negedge clk); sck = 1'b1;
         repeat (4) @(negedge clk); sck = 1'b0;
      end
      #3 rst = 1'b1;
      #1;
      chk("async_reset jugada", int'(jugada), 0);
      chk("async_reset dato_listo", int'(dato_listo), 0);
      chk("async_reset recibido", int'(recibido), 0);
      chk("async_reset frame_error", int'(frame_error), 0);
      ss = 1'b1; sck = 1'b0; mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      model_jug = 3'd0;
      run_frame(8'b1010_0_000, 8, 1'b1, 3'd0, "post_reset_col0");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
